dmem_responder: RTL and testbench

- Data-side memory responder for the pipelined RV32 core: the target of the core's mem_addr / mem_wr_data / mem_wr_sig / mem_rd_data data-memory interface.
- Provides a word-organised data RAM plus a small memory-mapped peripheral window: GPIO out, synchronised GPIO in, and a 32-bit timer with compare and interrupt flag.
- Read data is returned combinationally in the same cycle, because the core's MEM stage captures read data at the next edge. Writes commit on the clock edge.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_timer.sv | 69 ++++++
 rtl/dmem_responder.sv | 85 ++++++++
 tb/tb_dmem_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: peripheral register selects,
// timer control bit positions and the default peripheral window base.
package dmem_pkg;
  localparam logic [31:0] DEFAULT_PERIPH_BASE = 32'h1000_0000;

  // Register selects are word offsets within the window (mem_addr_i[7:2]).
  localparam logic [5:0] REG_GPIO_OUT   = 6'd0;
  localparam logic [5:0] REG_GPIO_IN    = 6'd1;
  localparam logic [5:0] REG_TIMER_CNT  = 6'd2;
  localparam logic [5:0] REG_TIMER_CMP  = 6'd3;
  localparam logic [5:0] REG_TIMER_CTRL = 6'd4;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_PEND    = 1;
  localparam int CTRL_AUTOCLR = 2;
endpackage

// File: rtl/dmem_timer.sv
// 32-bit free-running timer with compare, sticky pending flag and optional
// auto-clear of the counter on match.
module dmem_timer
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_i,
  input  logic [5:0]  sel_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] rd_data_o,
  output logic        irq_o
);
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic        pend_q, pend_d;
  logic        autoclr_q, autoclr_d;
  logic        match;
  logic        wr_cnt, wr_cmp, wr_ctrl;

  assign wr_cnt  = wr_i && (sel_i == REG_TIMER_CNT);
  assign wr_cmp  = wr_i && (sel_i == REG_TIMER_CMP);
  assign wr_ctrl = wr_i && (sel_i == REG_TIMER_CTRL);

  always_comb begin
    match = en_q && (cnt_q == cmp_q);
    // A core write to CNT beats both auto-clear and increment.
    cnt_d = cnt_q;
    if (wr_cnt)                 cnt_d = wr_data_i;
    else if (match && autoclr_q) cnt_d = '0;
    else if (en_q)              cnt_d = cnt_q + 32'd1;
    cmp_d     = wr_cmp  ? wr_data_i : cmp_q;
    en_d      = wr_ctrl ? wr_data_i[CTRL_EN] : en_q;
    autoclr_d = wr_ctrl ? wr_data_i[CTRL_AUTOCLR] : autoclr_q;
    // Set beats write-1-clear when both land in the same cycle.
    pend_d = pend_q;
    if (match)                                pend_d = 1'b1;
    else if (wr_ctrl && wr_data_i[CTRL_PEND]) pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      cmp_q     <= '0;
      en_q      <= 1'b0;
      pend_q    <= 1'b0;
      autoclr_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      cmp_q     <= cmp_d;
      en_q      <= en_d;
      pend_q    <= pend_d;
      autoclr_q <= autoclr_d;
    end
  end

  always_comb begin
    rd_data_o = '0;
    case (sel_i)
      REG_TIMER_CNT:  rd_data_o = cnt_q;
      REG_TIMER_CMP:  rd_data_o = cmp_q;
      REG_TIMER_CTRL: rd_data_o = {29'd0, autoclr_q, pend_q, en_q};
      default:        rd_data_o = '0;
    endcase
  end

  assign irq_o = pend_q;
endmodule

// File: rtl/dmem_responder.sv
// Data-side memory target for the RV32 core: word RAM plus a peripheral window
// (GPIO out, synchronised GPIO in, timer). Reads are combinational, writes commit on the edge.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          RAM_WORDS   = 1024,
  parameter logic [31:0] PERIPH_BASE = DEFAULT_PERIPH_BASE,
  parameter int          GPIO_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           mem_wr_data_i,
  input  logic                  mem_wr_sig_i,
  output logic [31:0]           mem_rd_data_o,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic                  timer_irq_o
);
  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]           ram_q [RAM_WORDS];
  logic [AW-1:0]         word_idx;
  logic [5:0]            reg_sel;
  logic                  ram_hit, periph_hit;
  logic [GPIO_WIDTH-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_WIDTH-1:0] gpio_meta_q, gpio_sync_q;
  logic [31:0]           timer_rd;
  logic                  unused_addr_lsbs;

  // Byte-lane bits are irrelevant: the core already merges lanes into full words.
  assign unused_addr_lsbs = ^mem_addr_i[1:0];

  assign ram_hit    = (mem_addr_i[31:AW+2] == '0);
  assign word_idx   = mem_addr_i[AW+1:2];
  assign periph_hit = (mem_addr_i[31:8] == PERIPH_BASE[31:8]);
  assign reg_sel    = mem_addr_i[7:2];

  always_ff @(posedge clk) begin
    if (mem_wr_sig_i && ram_hit) ram_q[word_idx] <= mem_wr_data_i;
  end

  always_comb begin
    gpio_out_d = gpio_out_q;
    if (mem_wr_sig_i && periph_hit && (reg_sel == REG_GPIO_OUT))
      gpio_out_d = mem_wr_data_i[GPIO_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gpio_out_q  <= '0;
      gpio_meta_q <= '0;
      gpio_sync_q <= '0;
    end else begin
      gpio_out_q  <= gpio_out_d;
      gpio_meta_q <= gpio_i;
      gpio_sync_q <= gpio_meta_q;
    end
  end

  dmem_timer u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_i      (mem_wr_sig_i && periph_hit),
    .sel_i     (reg_sel),
    .wr_data_i (mem_wr_data_i),
    .rd_data_o (timer_rd),
    .irq_o     (timer_irq_o)
  );

  always_comb begin
    mem_rd_data_o = '0;
    if (ram_hit) begin
      mem_rd_data_o = ram_q[word_idx];
    end else if (periph_hit) begin
      case (reg_sel)
        REG_GPIO_OUT: mem_rd_data_o = 32'(gpio_out_q);
        REG_GPIO_IN:  mem_rd_data_o = 32'(gpio_sync_q);
        default:      mem_rd_data_o = timer_rd;
      endcase
    end
  end

  assign gpio_o = gpio_out_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed bench for dmem_responder against a behavioural model
// of the memory map, GPIO synchroniser and timer rules.
module tb_dmem_responder;
  localparam logic [31:0] PB = 32'h1000_0000;

  logic        clk;
  logic        reset_n;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wr_data_i;
  logic        mem_wr_sig_i;
  logic [31:0] mem_rd_data_o;
  logic [7:0]  gpio_i;
  logic [7:0]  gpio_o;
  logic        timer_irq_o;

  dmem_responder #(.RAM_WORDS(1024), .PERIPH_BASE(PB), .GPIO_WIDTH(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_addr_i    (mem_addr_i),
    .mem_wr_data_i (mem_wr_data_i),
    .mem_wr_sig_i  (mem_wr_sig_i),
    .mem_rd_data_o (mem_rd_data_o),
    .gpio_i        (gpio_i),
    .gpio_o        (gpio_o),
    .timer_irq_o   (timer_irq_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [31:0] ram_m [1024];
  logic [31:0] m_cnt, m_cmp;
  logic        m_en, m_pend, m_ac;
  logic [7:0]  m_gpio;
  logic [7:0]  in_hist [2];
  logic [7:0]  gpio_drv;

  // scoreboard
  logic [31:0] exp_q [$];
  string       name_q [$];
  logic        chk;
  logic        mon_en;
  int          total;
  int          bad;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_cnt = 0; m_cmp = 0; m_en = 0; m_pend = 0; m_ac = 0; m_gpio = 0;
    in_hist[0] = 0; in_hist[1] = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a < 32'd4096) return ram_m[a[11:2]];
    if (a[31:8] != PB[31:8]) return 32'd0;
    case (a[7:2])
      6'd0: return {24'd0, m_gpio};
      6'd1: return {24'd0, in_hist[1]};
      6'd2: return m_cnt;
      6'd3: return m_cmp;
      6'd4: return {29'd0, m_ac, m_pend, m_en};
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock edge given what the core presented this cycle.
  function automatic void model_update(input logic [31:0] a, input logic we, input logic [31:0] d);
    logic       per = (a[31:8] == PB[31:8]);
    logic [5:0] s = a[7:2];
    logic       hit = m_en && (m_cnt == m_cmp);
    logic [31:0] next_cnt = m_cnt;
    logic        next_pend = m_pend;
    if (m_en) next_cnt = (hit && m_ac) ? 32'd0 : m_cnt + 32'd1;
    if (hit) next_pend = 1'b1;
    else if (we && per && s == 6'd4 && d[1]) next_pend = 1'b0;
    if (we && per) begin
      if (s == 6'd0) m_gpio = d[7:0];
      if (s == 6'd2) next_cnt = d;
      if (s == 6'd3) m_cmp = d;
      if (s == 6'd4) begin m_en = d[0]; m_ac = d[2]; end
    end
    if (we && a < 32'd4096) ram_m[a[11:2]] = d;
    m_cnt = next_cnt;
    m_pend = next_pend;
    in_hist[1] = in_hist[0];
    in_hist[0] = gpio_drv;
  endfunction

  // driver: called just after a rising edge, occupies exactly one cycle
  task automatic step(input logic [31:0] a, input logic we, input logic [31:0] d,
                      input string n, input bit do_chk, input bit use_c, input logic [31:0] cval);
    mem_addr_i = a; mem_wr_data_i = d; mem_wr_sig_i = we; gpio_i = gpio_drv;
    if (do_chk) begin
      exp_q.push_back(use_c ? cval : model_read(a));
      name_q.push_back(n);
      chk = 1'b1;
    end else begin
      chk = 1'b0;
    end
    @(posedge clk);
    model_update(a, we, d);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input string n);
    step(a, 1'b0, 32'd0, n, 1'b1, 1'b0, 32'd0);
  endtask
  task automatic rdc(input logic [31:0] a, input string n, input logic [31:0] v);
    step(a, 1'b0, 32'd0, n, 1'b1, 1'b1, v);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string n);
    step(a, 1'b1, d, n, 1'b1, 1'b0, 32'd0);
  endtask

  // monitor: read data presented in the cycle is compared at the falling edge
  always @(negedge clk) begin
    if (chk) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        check(name_q.pop_front(), mem_rd_data_o, exp_q.pop_front());
      end
    end
    if (mon_en) begin
      check("gpio_o", {24'd0, gpio_o}, {24'd0, m_gpio});
      check("timer_irq_o", {31'd0, timer_irq_o}, {31'd0, m_pend});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic        we;
    int          drain;
    total = 0; bad = 0; chk = 1'b0; mon_en = 1'b0;
    reset_n = 1'b0; mem_addr_i = 0; mem_wr_data_i = 0; mem_wr_sig_i = 0;
    gpio_drv = 0; gpio_i = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    mon_en = 1'b1;

    // reset values
    rdc(PB + 32'h00, "rst_gpio_out", 32'd0);
    rdc(PB + 32'h08, "rst_cnt", 32'd0);
    rdc(PB + 32'h0C, "rst_cmp", 32'd0);
    rdc(PB + 32'h10, "rst_ctrl", 32'd0);

    for (int i = 0; i < 1024; i++) step(32'(i * 4), 1'b1, $urandom, "init", 1'b0, 1'b0, 32'd0);

    // RAM round trip and byte-offset aliasing
    wr(32'h10, 32'hDEAD_BEEF, "ram_wr");
    rdc(32'h10, "ram_rd_10", 32'hDEAD_BEEF);
    rdc(32'h13, "ram_rd_13", 32'hDEAD_BEEF);
    rd(32'h14, "ram_rd_14");

    // unmapped
    step(32'h2000_0000, 1'b1, 32'h1234_5678, "unmap_wr", 1'b1, 1'b1, 32'd0);
    rdc(32'h2000_0000, "unmap_rd", 32'd0);
    rdc(32'd4096, "ram_end_rd", 32'd0);
    rd(32'h0, "ram_word0");

    // GPIO
    wr(PB, 32'h1A5, "gpio_wr");
    check("gpio_o_a5", {24'd0, gpio_o}, 32'hA5);
    rdc(PB, "gpio_out_rd", 32'hA5);
    gpio_drv = 8'h3C;
    rdc(PB + 32'h04, "gpio_in_e0", 32'd0);
    rdc(PB + 32'h04, "gpio_in_e1", 32'd0);
    rdc(PB + 32'h04, "gpio_in_e2", 32'h3C);

    // timer match with auto-clear, then stop and clear
    wr(PB + 32'h08, 32'd0, "t_cnt0");
    wr(PB + 32'h0C, 32'd5, "t_cmp5");
    wr(PB + 32'h10, 32'h5, "t_ctrl5");
    for (int k = 0; k <= 5; k++) rdc(PB + 32'h08, "t_count", 32'(k));
    rdc(PB + 32'h08, "t_autoclr", 32'd0);
    rdc(PB + 32'h10, "t_ctrl_pend", 32'h7);
    wr(PB + 32'h10, 32'h2, "t_clear");
    rdc(PB + 32'h10, "t_ctrl_clr", 32'h0);
    rdc(PB + 32'h08, "t_stopped_a", 32'd3);
    rdc(PB + 32'h08, "t_stopped_b", 32'd3);

    // clear on match cycle: set wins
    wr(PB + 32'h08, 32'd5, "s_cnt5");
    wr(PB + 32'h10, 32'h1, "s_en");
    wr(PB + 32'h10, 32'h3, "s_clr_on_match");
    rdc(PB + 32'h10, "s_pend_kept", 32'h3);
    // CNT write beats increment
    wr(PB + 32'h08, 32'd100, "s_cnt100");
    rdc(PB + 32'h08, "s_cnt_100", 32'd100);
    rdc(PB + 32'h08, "s_cnt_101", 32'd101);
    wr(PB + 32'h10, 32'h2, "s_stop");

    // wrap without flag, then match on zero
    wr(PB + 32'h0C, 32'd0, "w_cmp0");
    wr(PB + 32'h08, 32'hFFFF_FFFE, "w_cnt");
    wr(PB + 32'h10, 32'h1, "w_en");
    rdc(PB + 32'h08, "w_fffe", 32'hFFFF_FFFE);
    rdc(PB + 32'h08, "w_ffff", 32'hFFFF_FFFF);
    rdc(PB + 32'h10, "w_no_pend_yet", 32'h1);
    rdc(PB + 32'h10, "w_pend", 32'h3);
    rdc(PB + 32'h08, "w_cnt2", 32'd2);

    // asynchronous reset mid-count
    chk = 1'b0; mem_addr_i = PB + 32'h08; mem_wr_sig_i = 1'b0;
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_cnt", mem_rd_data_o, 32'd0);
    check("async_rst_irq", {31'd0, timer_irq_o}, 32'd0);
    check("async_rst_gpio", {24'd0, gpio_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    rdc(32'h10, "ram_after_rst", 32'hDEAD_BEEF);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      we = ($urandom_range(0, 2) == 0);
      d = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 32'($urandom_range(0, 4095));
        4: a = ($urandom_range(0, 1) == 1) ? 32'h2000_0000 + 32'($urandom_range(0, 255) * 4)
                                           : 32'd4096 + 32'($urandom_range(0, 1000));
        default: begin
          a = PB + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
          if (a[4:2] == 3'd2 || a[4:2] == 3'd3) d = 32'($urandom_range(0, 12));
          if (a[4:2] == 3'd4) d = 32'($urandom_range(0, 7));
        end
      endcase
      if ($urandom_range(0, 3) == 0) gpio_drv = 8'($urandom);
      step(a, we, d, "rand", 1'b1, 1'b0, 32'd0);
    end
    chk = 1'b0;
    mem_wr_sig_i = 1'b0;

    drain = 0;
    while (exp_q.size() != 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    if (exp_q.size() != 0) check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
